// File: rtl/cpu_instr_decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : cpu_instr_decode_queue
// Description : Registered decode stage between fetch and issue. Each
//               {pc, instr} accepted on the input handshake is fully decoded
//               (RV32I/M/F, R/I/S/B/U/J/R4 formats) and stored in a
//               DEPTH-entry circular queue. The head entry is presented to
//               issue over a second valid/ready handshake.
// Ports       : clk, rst (sync, active high), flush
//               in_valid/in_ready/in_instr/in_pc      - fetch side
//               out_valid/out_ready/out_*            - issue side (head entry)
//               count                                 - occupancy
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef CPU_INSTR_LENGTH
`define CPU_INSTR_LENGTH 32
`endif
`ifndef CPU_XLEN
`define CPU_XLEN 32
`endif
`ifndef CPU_GREGIDX_WIDTH
`define CPU_GREGIDX_WIDTH 5
`endif
`ifndef CPU_INSTR_DECODE_INFO_WIDTH
`define CPU_INSTR_DECODE_INFO_WIDTH 10
`endif
`ifndef CPU_INSTR_OPR_INVALID
`define CPU_INSTR_OPR_INVALID 5'b00000
`endif

module cpu_instr_decode_queue #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32,
    parameter int XLEN     = `CPU_XLEN
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [`CPU_INSTR_LENGTH-1:0]            in_instr,
    input  logic [PC_WIDTH-1:0]                     in_pc,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [PC_WIDTH-1:0]                     out_pc,
    output logic [6:0]                              out_opcode,
    output logic [`CPU_GREGIDX_WIDTH-1:0]           out_rd_idx,
    output logic [`CPU_GREGIDX_WIDTH-1:0]           out_rs1_idx,
    output logic [`CPU_GREGIDX_WIDTH-1:0]           out_rs2_idx,
    output logic [`CPU_GREGIDX_WIDTH-1:0]           out_rs3_idx,
    output logic [XLEN-1:0]                         out_imm,
    output logic [9:0]                              out_funct,
    output logic [`CPU_INSTR_DECODE_INFO_WIDTH-1:0] out_dec_info,
    output logic [2:0]                              out_fp_rm,
    output logic [1:0]                              out_fp_fmt,
    output logic                                    out_illegal,
    output logic [$clog2(DEPTH):0]                  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Group codes (upper half of dec_info)
    localparam logic [4:0] c_GRP_INVALID = 5'd0;
    localparam logic [4:0] c_GRP_LUI     = 5'd1;
    localparam logic [4:0] c_GRP_AUIPC   = 5'd2;
    localparam logic [4:0] c_GRP_JAL     = 5'd3;
    localparam logic [4:0] c_GRP_JALR    = 5'd4;
    localparam logic [4:0] c_GRP_BCC     = 5'd5;
    localparam logic [4:0] c_GRP_LOAD    = 5'd6;
    localparam logic [4:0] c_GRP_STORE   = 5'd7;
    localparam logic [4:0] c_GRP_ALUI    = 5'd8;
    localparam logic [4:0] c_GRP_ALU     = 5'd9;
    localparam logic [4:0] c_GRP_MULDIV  = 5'd10;
    localparam logic [4:0] c_GRP_FENCE   = 5'd11;
    localparam logic [4:0] c_GRP_E_CSR   = 5'd12;
    localparam logic [4:0] c_GRP_F_FLW   = 5'd13;
    localparam logic [4:0] c_GRP_F_FSW   = 5'd14;
    localparam logic [4:0] c_GRP_F_FMADD = 5'd15;
    localparam logic [4:0] c_GRP_F_FMSUB = 5'd16;
    localparam logic [4:0] c_GRP_F_FNMSUB= 5'd17;
    localparam logic [4:0] c_GRP_F_FNMADD= 5'd18;
    localparam logic [4:0] c_GRP_F_FOPR  = 5'd19;

    // Operand-mask bits (lower half of dec_info)
    localparam logic [4:0] c_OPR_RS1 = 5'b00001;
    localparam logic [4:0] c_OPR_RS2 = 5'b00010;
    localparam logic [4:0] c_OPR_RS3 = 5'b00100;
    localparam logic [4:0] c_OPR_RD  = 5'b01000;
    localparam logic [4:0] c_OPR_IMM = 5'b10000;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6,
        FMT_R4   = 3'd7
    } fmt_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0]                     pc;
        logic [`CPU_INSTR_LENGTH-1:0]            instr;
        logic [XLEN-1:0]                         imm;
        logic [9:0]                              funct;
        logic [`CPU_INSTR_DECODE_INFO_WIDTH-1:0] info;
        logic                                    illegal;
    } entry_t;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [4:0]      w_group;
    fmt_t            w_fmt;
    logic [XLEN-1:0] w_imm;
    logic [9:0]      w_funct;
    logic [4:0]      w_mask;
    logic [31:0]     w_i;

    assign w_i = in_instr;

    always_comb begin
        w_group = c_GRP_INVALID;
        w_fmt   = FMT_NONE;
        case (w_i[6:0])
            7'b0110111: begin w_group = c_GRP_LUI;      w_fmt = FMT_U;  end
            7'b0010111: begin w_group = c_GRP_AUIPC;    w_fmt = FMT_U;  end
            7'b1101111: begin w_group = c_GRP_JAL;      w_fmt = FMT_J;  end
            7'b1100111: begin w_group = c_GRP_JALR;     w_fmt = FMT_I;  end
            7'b1100011: begin w_group = c_GRP_BCC;      w_fmt = FMT_B;  end
            7'b0000011: begin w_group = c_GRP_LOAD;     w_fmt = FMT_I;  end
            7'b0100011: begin w_group = c_GRP_STORE;    w_fmt = FMT_S;  end
            7'b0010011: begin w_group = c_GRP_ALUI;     w_fmt = FMT_I;  end
            7'b0110011: begin
                w_group = w_i[25] ? c_GRP_MULDIV : c_GRP_ALU;
                w_fmt   = FMT_R;
            end
            7'b0001111: begin w_group = c_GRP_FENCE;    w_fmt = FMT_I;  end
            7'b1110011: begin w_group = c_GRP_E_CSR;    w_fmt = FMT_I;  end
            7'b0000111: begin w_group = c_GRP_F_FLW;    w_fmt = FMT_I;  end
            7'b0100111: begin w_group = c_GRP_F_FSW;    w_fmt = FMT_S;  end
            7'b1000011: begin w_group = c_GRP_F_FMADD;  w_fmt = FMT_R4; end
            7'b1000111: begin w_group = c_GRP_F_FMSUB;  w_fmt = FMT_R4; end
            7'b1001011: begin w_group = c_GRP_F_FNMSUB; w_fmt = FMT_R4; end
            7'b1001111: begin w_group = c_GRP_F_FNMADD; w_fmt = FMT_R4; end
            7'b1010011: begin w_group = c_GRP_F_FOPR;   w_fmt = FMT_R;  end
            default:    begin w_group = c_GRP_INVALID;  w_fmt = FMT_NONE; end
        endcase
        // Compressed-encoding space is not supported: treat as undecodable.
        if (w_i[1:0] != 2'b11) begin
            w_group = c_GRP_INVALID;
            w_fmt   = FMT_NONE;
        end
    end

    always_comb begin
        w_imm   = '0;
        w_funct = '0;
        w_mask  = `CPU_INSTR_OPR_INVALID;
        case (w_fmt)
            FMT_R: begin
                w_funct = {w_i[31:25], w_i[14:12]};
                w_mask  = c_OPR_RS1 | c_OPR_RS2 | c_OPR_RD;
            end
            FMT_I: begin
                w_imm   = {{(XLEN-12){w_i[31]}}, w_i[31:20]};
                w_funct = {7'b0, w_i[14:12]};
                w_mask  = c_OPR_RS1 | c_OPR_RD | c_OPR_IMM;
            end
            FMT_S: begin
                w_imm   = {{(XLEN-12){w_i[31]}}, w_i[31:25], w_i[11:7]};
                w_funct = {7'b0, w_i[14:12]};
                w_mask  = c_OPR_RS1 | c_OPR_RS2 | c_OPR_IMM;
            end
            FMT_B: begin
                w_imm   = {{(XLEN-13){w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
                w_funct = {7'b0, w_i[14:12]};
                w_mask  = c_OPR_RS1 | c_OPR_RS2 | c_OPR_IMM;
            end
            FMT_U: begin
                w_imm   = {{(XLEN-31){w_i[31]}}, w_i[30:12], 12'b0};
                w_mask  = c_OPR_RD | c_OPR_IMM;
            end
            FMT_J: begin
                w_imm   = {{(XLEN-21){w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};
                w_mask  = c_OPR_RD | c_OPR_IMM;
            end
            FMT_R4: begin
                w_funct = {5'b0, w_i[26:25], w_i[14:12]};
                w_mask  = c_OPR_RS1 | c_OPR_RS2 | c_OPR_RS3 | c_OPR_RD;
            end
            default: begin
                w_imm   = '0;
                w_funct = '0;
                w_mask  = `CPU_INSTR_OPR_INVALID;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Circular queue
    // ------------------------------------------------------------------
    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;
    entry_t          w_new;
    entry_t          w_head;

    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    // in_ready is taken from the pre-edge count, so a full queue never
    // accepts even when the head pops in the same cycle.
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign w_new.pc      = in_pc;
    assign w_new.instr   = in_instr;
    assign w_new.imm     = w_imm;
    assign w_new.funct   = w_funct;
    assign w_new.info    = {w_group, w_mask};
    assign w_new.illegal = (w_group == c_GRP_INVALID);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: every output is gated by out_valid.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_push) begin
            r_mem[r_wr_ptr] <= w_new;
        end
    end

    assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;

    assign count        = r_count;
    assign out_pc       = w_head.pc;
    assign out_opcode   = w_head.instr[6:0];
    assign out_rd_idx   = w_head.instr[11:7];
    assign out_rs1_idx  = w_head.instr[19:15];
    assign out_rs2_idx  = w_head.instr[24:20];
    assign out_rs3_idx  = w_head.instr[31:27];
    assign out_imm      = w_head.imm;
    assign out_funct    = w_head.funct;
    assign out_dec_info = w_head.info;
    assign out_fp_rm    = w_head.instr[14:12];
    assign out_fp_fmt   = w_head.instr[26:25];
    assign out_illegal  = w_head.illegal;

endmodule

`default_nettype wire

// File: doc/cpu_instr_decode_queue.md
Name: cpu_instr_decode_queue

Overview:
- Registered, buffered decode stage between instruction fetch and issue. It accepts {pc, instr} over a valid/ready handshake and fully decodes each instruction at enqueue (RV32I, M, F; R/I/S/B/U/J/R4 formats).
- Decoded entries are held in a DEPTH-entry circular queue and presented to issue over a second valid/ready handshake.
- Over the combinational decoder it adds: rs3 extraction, an illegal-instruction flag, the PC carried with each instruction, flush support, and back-pressure.

Parameters:
- DEPTH, 4, number of queue entries; power of two, ≥2.
- PC_WIDTH, 32, width of the program-counter field carried per entry.
- XLEN, 32, immediate width; must equal `CPU_XLEN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all queued entries (branch mispredict or trap).
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  queue can accept; equals (count != DEPTH).
- in_instr  input  `CPU_INSTR_LENGTH  raw instruction word.
- in_pc  input  PC_WIDTH  PC of in_instr.
- out_valid  output  1  head entry valid; equals (count != 0).
- out_ready  input  1  issue consumes the head entry.
- out_pc  output  PC_WIDTH  head PC.
- out_opcode  output  7  instr[6:0].
- out_rd_idx, out_rs1_idx, out_rs2_idx, out_rs3_idx  output  `CPU_GREGIDX_WIDTH each  instr[11:7], [19:15], [24:20], [31:27].
- out_imm  output  XLEN  sign- or zero-formed immediate.
- out_funct  output  10  format-dependent funct field.
- out_dec_info  output  `CPU_INSTR_DECODE_INFO_WIDTH  {group, operand-mask}.
- out_fp_rm  output  3  instr[14:12].
- out_fp_fmt  output  2  instr[26:25].
- out_illegal  output  1  head entry is not a decodable instruction.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=1 at a clock edge):
  - wr_ptr, rd_ptr and count go to 0, so out_valid=0 and in_ready=1.
  - All out_* data fields read 0: storage is cleared, or outputs are gated by out_valid.
  - Reset takes priority over flush, push and pop in the same cycle. Reset mid-stream drops every entry; no partial entry is ever emitted.
- Push: occurs when in_valid && in_ready.
  - Decode is combinational on in_instr.
  - The decoded record is written to entry wr_ptr and wr_ptr increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready; rd_ptr increments modulo DEPTH.
- Count update:
  - Push only: count+1.
  - Pop only: count−1.
  - Push and pop together: unchanged, including count=1 (the head pops and the new entry becomes the next head).
  - Full (count=DEPTH): in_ready=0; a push is not accepted even if a pop happens that cycle (no pass-through).
  - Empty: out_valid=0 and out_ready is ignored.
- Latency: an instruction pushed at edge N is visible on out_* after edge N when it is the head. Minimum latency is 1 cycle. There is no combinational path from in_* to out_*.
- Flush: at the edge with flush=1, pointers and count go to 0. Any simultaneous push or pop is discarded. The next cycle shows out_valid=0 and in_ready=1.
- Ordering: strict FIFO. Head outputs stay stable while out_valid && !out_ready.
- Decode, group by opcode:
  - 0110111 = LUI (U).
  - 0010111 = AUIPC (U).
  - 1101111 = JAL (J).
  - 1100111 = JALR (I).
  - 1100011 = BCC (B).
  - 0000011 = LOAD (I).
  - 0100011 = STORE (S).
  - 0010011 = ALUI (I).
  - 0110011 = ALU (R) when instr[25]=0, MULDIV (R) when instr[25]=1.
  - 0001111 = FENCE (I).
  - 1110011 = E_CSR (I).
  - 0000111 = F_FLW (I).
  - 0100111 = F_FSW (S).
  - 1000011, 1000111, 1001011, 1001111 = F_FMADD, F_FMSUB, F_FNMSUB, F_FNMADD (R4).
  - 1010011 = F_FOPR (R).
  - Any other opcode = INVALID.
- Immediate by format:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U: {instr[31:12], 12'b0}.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - R, R4, INVALID: 0.
- funct by format:
  - R: {instr[31:25], instr[14:12]}.
  - I, S, B: {7'b0, instr[14:12]}.
  - R4: {5'b0, instr[26:25], instr[14:12]}.
  - U, J, INVALID: 0.
- Operand mask by format:
  - R: RS1|RS2|RD.
  - I: RS1|RD|IMM.
  - S and B: RS1|RS2|IMM.
  - U and J: RD|IMM.
  - R4: RS1|RS2|RS3|RD.
  - INVALID: `CPU_INSTR_OPR_INVALID.
- out_illegal=1 when the group is INVALID or instr[1:0] != 2'b11. When instr[1:0] != 2'b11 the group is also forced to INVALID.
- Illegal entries are still queued and delivered in order so the trap is taken precisely.

Test Plan:
- Reset, then push ADDI x1,x2,-1 (0xFFF10093, pc=0x100) with out_ready=0 → the next cycle shows out_valid=1, rd=1, rs1=2, imm=0xFFFFFFFF, funct=0x000, group ALUI, illegal=0, pc=0x100; outputs hold while stalled.
- Push LUI 0x123450B7 then MUL 0x022081B3 → LUI first with imm=0x12345000 and mask RD|IMM; then MUL with rd=3, rs1=1, rs2=2, funct=0x008, group MULDIV.
- Push 5 instructions with out_ready=0 and DEPTH=4 → in_ready drops after the 4th push and count=4. Assert out_ready together with in_valid while full → the 5th push is not accepted that cycle and is accepted the next cycle. Order is preserved across pointer wrap.
- With count=3, assert flush together with in_valid and out_ready → the next cycle shows count=0 and out_valid=0; the simultaneous push is dropped.
- Push 0x00000000 and then 0x00000013 → the first entry has illegal=1, group INVALID, imm=0; the second is a legal NOP. Both are delivered in order.
- Stream continuously with count=1 and push+pop every cycle for 16 cycles → count stays 1 and every instruction appears exactly once. Assert rst mid-stream → the next cycle shows out_valid=0, count=0 and in_ready=1.
